// File: rtl/dvfs_sequencer.sv
// DVFS step sequencer: moves the operating point one level at a time,
// raising voltage before frequency and lowering frequency before voltage.
module dvfs_sequencer #(
    parameter int RESET_LEVEL = 2,
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] target_level,
    input  logic       temp_trip,
    input  logic       vreg_ack,
    input  logic       pll_lock,
    output logic [2:0] volt_level,
    output logic       vreg_req,
    output logic [2:0] freq_level,
    output logic       pll_req,
    output logic [2:0] cur_level,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        V_UP,
        F_UP,
        F_DN,
        V_DN,
        SETTLE
    } state_e;

    localparam logic [2:0]  RST_LVL  = 3'(RESET_LEVEL);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYC);
    localparam logic [15:0] SET_LAST =
        (SETTLE_CYC > 1) ? 16'(SETTLE_CYC - 1) : 16'd0;

    state_e      state_q, state_d;
    logic [2:0]  cur_q, cur_d;
    logic [2:0]  volt_q, volt_d;
    logic [2:0]  freq_q, freq_d;
    logic        vreq_q, vreq_d;
    logic        preq_q, preq_d;
    logic        fault_q, fault_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] settle_q, settle_d;

    logic [2:0]  eff_tgt;
    logic [2:0]  lvl_up;
    logic [2:0]  lvl_dn;
    logic [15:0] wait_inc;
    logic        waiting;
    logic        got;

    assign eff_tgt  = temp_trip ? 3'd0 : target_level;
    assign lvl_up   = (cur_q == 3'd7) ? 3'd7 : cur_q + 3'd1;
    assign lvl_dn   = (cur_q == 3'd0) ? 3'd0 : cur_q - 3'd1;
    assign wait_inc = wait_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        volt_d   = volt_q;
        freq_d   = freq_q;
        vreq_d   = vreq_q;
        preq_d   = preq_q;
        fault_d  = fault_q;
        wait_d   = wait_q;
        settle_d = settle_q;
        waiting  = 1'b0;
        got      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (eff_tgt > cur_q && !fault_q) begin
                    state_d = V_UP;
                    volt_d  = lvl_up;
                    vreq_d  = 1'b1;
                    wait_d  = '0;
                end else if (eff_tgt < cur_q) begin
                    state_d = F_DN;
                    freq_d  = lvl_dn;
                    preq_d  = 1'b1;
                    wait_d  = '0;
                end
            end
            V_UP: begin
                waiting = 1'b1;
                got     = vreg_ack;
                if (vreg_ack) begin
                    vreq_d  = 1'b0;
                    freq_d  = lvl_up;
                    preq_d  = 1'b1;
                    wait_d  = '0;
                    state_d = F_UP;
                end
            end
            F_UP: begin
                waiting = 1'b1;
                got     = pll_lock;
                if (pll_lock) begin
                    preq_d   = 1'b0;
                    cur_d    = lvl_up;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            F_DN: begin
                waiting = 1'b1;
                got     = pll_lock;
                if (pll_lock) begin
                    preq_d  = 1'b0;
                    cur_d   = lvl_dn;
                    volt_d  = lvl_dn;
                    vreq_d  = 1'b1;
                    wait_d  = '0;
                    state_d = V_DN;
                end
            end
            V_DN: begin
                waiting = 1'b1;
                got     = vreg_ack;
                if (vreg_ack) begin
                    vreq_d   = 1'b0;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stuck handshake drops both requests and pulls the PLL back
        // to the committed level; voltage stays where it is (safe side).
        if (waiting && !got) begin
            if (wait_inc == TO_LIM) begin
                vreq_d  = 1'b0;
                preq_d  = 1'b0;
                freq_d  = cur_q;
                fault_d = 1'b1;
                state_d = IDLE;
            end else begin
                wait_d = wait_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= RST_LVL;
            volt_q   <= RST_LVL;
            freq_q   <= RST_LVL;
            vreq_q   <= 1'b0;
            preq_q   <= 1'b0;
            fault_q  <= 1'b0;
            wait_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            volt_q   <= volt_d;
            freq_q   <= freq_d;
            vreq_q   <= vreq_d;
            preq_q   <= preq_d;
            fault_q  <= fault_d;
            wait_q   <= wait_d;
            settle_q <= settle_d;
        end
    end

    assign volt_level = volt_q;
    assign vreg_req   = vreq_q;
    assign freq_level = freq_q;
    assign pll_req    = preq_q;
    assign cur_level  = cur_q;
    assign busy       = (state_q != IDLE);
    assign fault      = fault_q;

endmodule

// File: tb/tb_dvfs_sequencer.sv
// Scoreboard bench for dvfs_sequencer: a level-stepping model predicts
// every completed step; a monitor checks each return to IDLE.
module tb_dvfs_sequencer;

    localparam int RL = 2;
    localparam int SC = 64;
    localparam int TC = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] target_level;
    logic       temp_trip;
    logic       vreg_ack;
    logic       pll_lock;
    logic [2:0] volt_level;
    logic       vreg_req;
    logic [2:0] freq_level;
    logic       pll_req;
    logic [2:0] cur_level;
    logic       busy;
    logic       fault;

    always #5 clk = ~clk;

    dvfs_sequencer #(
        .RESET_LEVEL(RL),
        .SETTLE_CYC (SC),
        .TIMEOUT_CYC(TC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .target_level(target_level),
        .temp_trip   (temp_trip),
        .vreg_ack    (vreg_ack),
        .pll_lock    (pll_lock),
        .volt_level  (volt_level),
        .vreg_req    (vreg_req),
        .freq_level  (freq_level),
        .pll_req     (pll_req),
        .cur_level   (cur_level),
        .busy        (busy),
        .fault       (fault)
    );

    typedef struct packed {
        logic [2:0]  cur;
        logic [2:0]  volt;
        logic [2:0]  freq;
        logic        flt;
        logic [15:0] settle;
    } step_t;

    step_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    m_cur, m_volt, m_freq;
    bit    m_fault;
    int    hs_drop = 0;
    int    ack_dly = 3;
    int    lock_dly = 3;
    int    vc = 0;
    int    pc = 0;
    int    last_fall = 0;
    bit    pb = 0, pv = 0, pp = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic void push_step(int settle);
        step_t e;
        e.cur    = 3'(m_cur);
        e.volt   = 3'(m_volt);
        e.freq   = 3'(m_freq);
        e.flt    = m_fault;
        e.settle = 16'(settle);
        exp_q.push_back(e);
    endfunction

    // Walk the model one level at a time toward eff, recording each step.
    function automatic void plan(int eff);
        while (eff != m_cur) begin
            if (eff > m_cur) begin
                if (m_fault) break;
                if (hs_drop != 0) begin
                    m_volt  = m_cur + 1;
                    m_freq  = m_cur;
                    m_fault = 1'b1;
                    push_step(0);
                    break;
                end
                m_cur++;
            end else begin
                m_cur--;
            end
            m_volt = m_cur;
            m_freq = m_cur;
            push_step(SC);
        end
    endfunction

    // Regulator/PLL responder with stray ack/lock noise outside requests.
    initial begin
        vreg_ack = 1'b0;
        pll_lock = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (vreg_req && hs_drop != 1) begin
                vc++;
                vreg_ack = (vc >= ack_dly);
            end else begin
                vc = 0;
                vreg_ack = !vreg_req && ($urandom_range(0, 3) == 0);
            end
            if (pll_req && hs_drop != 2) begin
                pc++;
                pll_lock = (pc >= lock_dly);
            end else begin
                pc = 0;
                pll_lock = !pll_req && ($urandom_range(0, 3) == 0);
            end
        end
    end

    initial begin
        step_t e;
        step_t a;
        forever begin
            @(negedge clk);
            if (rst) begin
                pb = 0;
                pv = 0;
                pp = 0;
            end else begin
                chk("volt_ge_freq", 32'(volt_level >= freq_level), 1);
                if ((pv && !vreg_req) || (pp && !pll_req)) last_fall = cyc;
                if (pb && !busy) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL stray_step: got cur %0d, expected none",
                                 cur_level);
                    end else begin
                        e = exp_q.pop_front();
                        a.cur    = cur_level;
                        a.volt   = volt_level;
                        a.freq   = freq_level;
                        a.flt    = fault;
                        a.settle = 16'(cyc - last_fall);
                        if (a !== e) begin
                            n_fail++;
                            $display({"FAIL step: got c%0d v%0d f%0d flt%0d s%0d",
                                      " expected c%0d v%0d f%0d flt%0d s%0d"},
                                     a.cur, a.volt, a.freq, a.flt, a.settle,
                                     e.cur, e.volt, e.freq, e.flt, e.settle);
                        end
                    end
                end
                pb = busy;
                pv = vreg_req;
                pp = pll_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst = 1'b1;
        target_level = 3'(RL);
        temp_trip = 1'b0;
        hs_drop = 0;
        tick();
        chk("rst_cur", cur_level, RL);
        chk("rst_volt", volt_level, RL);
        chk("rst_freq", freq_level, RL);
        chk("rst_vreq", vreg_req, 0);
        chk("rst_preq", pll_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        tick();
        rst = 1'b0;
        m_cur = RL;
        m_volt = RL;
        m_freq = RL;
        m_fault = 1'b0;
    endtask

    task automatic cmd(input int tgt, input bit trip);
        target_level = 3'(tgt);
        temp_trip = trip;
        plan(trip ? 0 : tgt);
    endtask

    task automatic wait_idle(input string name);
        int i;
        repeat (3) tick();
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < 20000) begin
            tick();
            i++;
        end
        chk({name, "_done"}, 32'(exp_q.size() == 0 && !busy), 1);
        exp_q.delete();
        chk({name, "_cur"}, cur_level, m_cur);
        chk({name, "_volt"}, volt_level, m_volt);
        chk({name, "_freq"}, freq_level, m_freq);
        chk({name, "_fault"}, fault, 32'(m_fault));
    endtask

    task automatic wait_sig(input string name, input bit use_pll,
                            input bit lvl, input int lim);
        int i;
        i = 0;
        while ((use_pll ? pll_req : vreg_req) != lvl && i < lim) begin
            tick();
            i++;
        end
        chk(name, 32'(use_pll ? pll_req : vreg_req), 32'(lvl));
    endtask

    initial begin
        int t, t2, mode, i, t0;
        rst = 1'b1;
        target_level = 3'(RL);
        temp_trip = 1'b0;
        do_reset();

        ack_dly = 5;
        lock_dly = 10;
        cmd(3, 0);
        wait_idle("up1");

        do_reset();
        ack_dly = 2;
        lock_dly = 4;
        cmd(0, 0);
        wait_idle("down2");

        cmd(5, 0);
        wait_sig("mid_fup", 1'b1, 1'b1, 200);
        do_reset();
        wait_idle("post_rst");

        for (int k = 0; k < 20; k++) begin
            ack_dly = $urandom_range(1, 12);
            lock_dly = $urandom_range(1, 12);
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                if (m_cur == 7) t = 6;
                else if (m_cur == 0) t = 1;
                else t = $urandom_range(0, 1) ? m_cur + 1 : m_cur - 1;
                cmd(t, 0);
                i = 0;
                while (!busy && i < 10) begin
                    tick();
                    i++;
                end
                chk("mid_busy", busy, 1);
                repeat ($urandom_range(0, 2)) tick();
                t2 = $urandom_range(0, 7);
                target_level = 3'(t2);
                plan(t2);
            end else begin
                cmd($urandom_range(0, 7), $urandom_range(0, 4) == 0);
            end
            wait_idle("rand");
        end

        do_reset();
        ack_dly = 3;
        lock_dly = 8;
        cmd(3, 0);
        wait_sig("therm_fup", 1'b1, 1'b1, 200);
        temp_trip = 1'b1;
        plan(0);
        wait_idle("thermal");
        cmd(3, 0);
        wait_idle("therm_rel");

        do_reset();
        hs_drop = 1;
        cmd(5, 0);
        wait_sig("to_vreq_up", 1'b0, 1'b1, 20);
        t0 = cyc;
        wait_sig("to_vreq_dn", 1'b0, 1'b0, 1200);
        chk("to_len", cyc - t0, TC);
        wait_idle("to_v");
        chk("to_fault", fault, 1);
        chk("to_freq", freq_level, 2);
        chk("to_volt", volt_level, 3);
        hs_drop = 0;
        cmd(7, 0);
        wait_idle("fault_hold");
        cmd(0, 0);
        wait_idle("fault_down");

        do_reset();
        hs_drop = 2;
        ack_dly = 4;
        cmd(4, 0);
        wait_idle("to_p");
        hs_drop = 0;
        cmd(1, 0);
        wait_idle("to_p_down");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dvfs_sequencer.md
DVFS_SEQUENCER -- requirements
Module: dvfs_sequencer

Parameters
REQ-001 The block SHALL have parameter RESET_LEVEL, default 2: the level that the frequency and voltage outputs take at reset.
REQ-002 The block SHALL have parameter SETTLE_CYC, default 64: the number of idle cycles between two steps.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1024: the maximum number of cycles to wait for vreg_ack or pll_lock.

Interface
REQ-004 `clk`  in  1  single clock; all logic is on its rising edge.
REQ-005 `rst`  in  1  synchronous, active-high reset.
REQ-006 `target_level`  in  3  requested operating level from the governor, 0..7.
REQ-007 `temp_trip`  in  1  thermal emergency; while high, the effective target is 0.
REQ-008 `vreg_ack`  in  1  regulator has settled at `volt_level`.
REQ-009 `pll_lock`  in  1  PLL is locked at `freq_level`.
REQ-010 `volt_level`  out  3  voltage code sent to the regulator.
REQ-011 `vreg_req`  out  1  voltage change request; held high until ack.
REQ-012 `freq_level`  out  3  frequency code sent to the PLL.
REQ-013 `pll_req`  out  1  relock request; held high until lock.
REQ-014 `cur_level`  out  3  committed frequency level.
REQ-015 `busy`  out  1  high when the state is not IDLE.
REQ-016 `fault`  out  1  sticky handshake-timeout flag.

Function
REQ-017 States SHALL be IDLE, V_UP, F_UP, F_DN, V_DN and SETTLE.
REQ-018 Effective target: eff_tgt = temp_trip ? 0 : target_level, sampled only in IDLE.
REQ-019 Each transition SHALL move exactly one level; multi-level targets are reached by repeated steps.
REQ-020 IDLE with eff_tgt > cur_level and fault = 0:
- next state V_UP;
- volt_level <= cur_level+1;
- vreg_req <= 1.
REQ-021 V_UP with vreg_ack = 1:
- vreg_req <= 0;
- freq_level <= cur_level+1;
- pll_req <= 1;
- next state F_UP.
REQ-022 F_UP with pll_lock = 1:
- pll_req <= 0;
- cur_level <= cur_level+1;
- next state SETTLE.
REQ-023 IDLE with eff_tgt < cur_level (allowed even when fault = 1):
- next state F_DN;
- freq_level <= cur_level-1;
- pll_req <= 1.
REQ-024 F_DN with pll_lock = 1:
- pll_req <= 0;
- cur_level <= cur_level-1;
- volt_level <= cur_level-1;
- vreg_req <= 1;
- next state V_DN.
REQ-025 V_DN with vreg_ack = 1: vreg_req <= 0; next state SETTLE.
REQ-026 SETTLE SHALL last exactly SETTLE_CYC cycles and then enter IDLE; targets are ignored during SETTLE.
REQ-027 Ordering and invariant:
- up-steps raise voltage before frequency;
- down-steps lower frequency before voltage;
- volt_level >= freq_level in every cycle.
REQ-028 A 16-bit wait counter SHALL clear on entry to V_UP, F_UP, F_DN and V_DN and increment each cycle the awaited input is low.
REQ-029 When the wait counter reaches TIMEOUT_CYC:
- vreg_req <= 0 and pll_req <= 0;
- freq_level <= cur_level;
- volt_level is held;
- fault <= 1;
- next state IDLE with no SETTLE.
REQ-030 While fault = 1, no up-step SHALL start; fault clears only on rst.
REQ-031 vreg_ack or pll_lock that is high outside its wait state SHALL be ignored.
REQ-032 A change of target_level or temp_trip mid-step SHALL NOT abort the step; the new value is evaluated at the next IDLE.
REQ-033 In IDLE with eff_tgt == cur_level, the block SHALL stay in IDLE with all outputs unchanged.
REQ-034 Request outputs SHALL be registered; each asserts the cycle after state entry.
REQ-035 cur_level SHALL saturate in 0..7 and never wrap.

Reset
REQ-036 While rst = 1:
- state IDLE;
- freq_level = volt_level = cur_level = RESET_LEVEL;
- vreg_req = pll_req = busy = fault = 0;
- counters cleared.
REQ-037 rst asserted mid-step SHALL abandon the step in the same cycle with no handshake completion.

Verification
REQ-038 Up-step:
- stimulus: target 3 from reset; ack 5 cycles after vreg_req; lock 10 cycles after pll_req;
- response: volt_level = 3 before freq_level = 3; cur_level = 3; busy drops 64 cycles after lock.
REQ-039 Multi-step down:
- stimulus: target 0 from level 2;
- response: two F_DN/V_DN sequences; freq_level changes before volt_level each step; final cur_level = 0.
REQ-040 Timeout:
- stimulus: target 5 from reset; vreg_ack never asserted;
- response: after 1024 cycles vreg_req = 0, fault = 1, freq_level = 2, volt_level = 3; later target 7 starts no step.
REQ-041 Fault then down:
- stimulus: with fault = 1, target 0;
- response: down-steps complete to level 0.
REQ-042 Thermal:
- stimulus: temp_trip pulses during F_UP of a 2->3 step;
- response: the step completes to 3, then the block steps down to 0 while temp_trip is high.
REQ-043 Reset mid-step:
- stimulus: rst during F_UP;
- response: next cycle all outputs equal reset values and pll_req = 0.
